mem_req_arbiter: RTL and testbench

//  Two-requester arbiter sharing one synchronous-read data memory port.

---
 rtl/mem_req_arbiter_if.sv | 51 +++++
 rtl/mem_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester, response and memory-port signals of the two-port memory arbiter
interface mem_req_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0: CPU load/store path
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  // Port 1: program-loader / DMA path, with burst lock
  logic          p1_req;
  logic          p1_we;
  logic          p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  // Shared synchronous-read memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - fixed-priority two-port memory arbiter with starvation limit and burst lock
module mem_req_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_req_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          wait_hit;

  logic          p0_gnt, p1_gnt;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // Read-return tracking: one outstanding read, tagged with its owner (0/1)
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic          p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;

  assign wait_hit = (wait_cnt_q == WAIT_LIMIT);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter LOCK1 on a locked p1 grant, leave as soon as the lock drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (p1_gnt && bus.p1_lock) begin
          state_d = LOCK1;
        end
      end
      LOCK1: begin
        if (!bus.p1_lock) begin
          state_d = ARB;
        end
      end
    endcase
  end

  // Grant outputs: p0 has priority unless p1 has waited MAX_WAIT cycles or holds the lock
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset_i) begin
      case (state_q)
        ARB: begin
          if (bus.p1_req && (!bus.p0_req || wait_hit)) begin
            p1_gnt = 1'b1;
          end else if (bus.p0_req) begin
            p0_gnt = 1'b1;
          end
        end
        LOCK1: begin
          p1_gnt = bus.p1_req;
        end
      endcase
    end
  end

  // Starvation counter: counts denied p1 cycles in ARB, saturating, frozen during a lock
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ARB) begin
      if (p1_gnt || !bus.p1_req) begin
        wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < WAIT_LIMIT) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Memory port mux: fields follow the granted port, all zero when idle
  always_comb begin
    mem_en    = p0_gnt | p1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p1_gnt) begin
      mem_we    = bus.p1_we;
      mem_addr  = bus.p1_addr;
      mem_wdata = bus.p1_wdata;
    end else if (p0_gnt) begin
      mem_we    = bus.p0_we;
      mem_addr  = bus.p0_addr;
      mem_wdata = bus.p0_wdata;
    end
  end

  // Read-return routing: rvalid follows a read grant by one cycle, dropped while in reset
  always_comb begin
    rd_pend_d  = mem_en & ~mem_we;
    rd_owner_d = p1_gnt;
    p0_rvalid  = rd_pend_q & ~rd_owner_q & ~reset_i;
    p1_rvalid  = rd_pend_q &  rd_owner_q & ~reset_i;
    p0_rdata_d = p0_rvalid ? bus.mem_rdata : p0_rdata_q;
    p1_rdata_d = p1_rvalid ? bus.mem_rdata : p1_rdata_q;
  end

  // Read-return registers: pending flag, owner tag and last delivered data per port
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.p0_rvalid = p0_rvalid;
  assign bus.p1_rvalid = p1_rvalid;
  assign bus.p0_rdata  = reset_i ? '0 : p0_rdata_d;
  assign bus.p1_rdata  = reset_i ? '0 : p1_rdata_d;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_req_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model contents: fixed word at 0x10, otherwise A5A5 tagged with the low address bits
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  // Synchronous-read memory: data appears the cycle after a read strobe
  always @(posedge clk) begin
    if (reset) bus.mem_rdata <= 32'h0;
    else if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_fn(bus.mem_addr);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic exp1;

  initial begin
    reset        = 1'b1;
    bus.p0_req   = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
    bus.p1_req   = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
    bus.p1_lock  = 1'b0;

    // Reset state
    tick();
    mid();
    chk1 ("rst_p0_gnt",    bus.p0_gnt,    1'b0);
    chk1 ("rst_p1_gnt",    bus.p1_gnt,    1'b0);
    chk1 ("rst_mem_en",    bus.mem_en,    1'b0);
    chk1 ("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
    chk1 ("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk32("rst_p0_rdata",  bus.p0_rdata,  32'h0);
    chk32("rst_p1_rdata",  bus.p1_rdata,  32'h0);
    tick();
    reset = 1'b0;

    // Single p0 read of 0x10
    bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
    mid();
    chk1 ("t1_p0_gnt",   bus.p0_gnt,   1'b1);
    chk1 ("t1_p1_gnt",   bus.p1_gnt,   1'b0);
    chk1 ("t1_mem_en",   bus.mem_en,   1'b1);
    chk32("t1_mem_addr", bus.mem_addr, 32'h10);
    tick();
    bus.p0_req = 1'b0;
    mid();
    chk1 ("t1_p0_rvalid", bus.p0_rvalid, 1'b1);
    chk32("t1_p0_rdata",  bus.p0_rdata,  32'hDEADBEEF);
    chk1 ("t1_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk1 ("t1_mem_en_idle", bus.mem_en,  1'b0);
    tick();
    mid();
    chk1 ("t1_p0_rvalid_off", bus.p0_rvalid, 1'b0);
    chk32("t1_p0_rdata_hold", bus.p0_rdata,  32'hDEADBEEF);
    tick();

    // Both ports requesting: p1 wins once every five cycles
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h100;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      mid();
      exp1 = (k == 4) || (k == 9);
      chk1($sformatf("t2_p1_gnt_c%0d", k), bus.p1_gnt, exp1);
      chk1($sformatf("t2_p0_gnt_c%0d", k), bus.p0_gnt, !exp1);
      if (k == 5) begin
        chk1 ("t2_p1_rvalid", bus.p1_rvalid, 1'b1);
        chk32("t2_p1_rdata",  bus.p1_rdata,  32'hA5A50200);
        chk1 ("t2_p0_rvalid", bus.p0_rvalid, 1'b0);
      end
      tick();
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    mid();
    chk1("t2_tail_p1_rvalid", bus.p1_rvalid, 1'b1);
    chk1("t2_tail_p0_rvalid", bus.p0_rvalid, 1'b0);
    tick();

    // Locked p1 write burst holds p0 off until the lock drops
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_lock = 1'b1;
    bus.p1_addr = 32'h20; bus.p1_wdata = 32'h000000AA;
    bus.p0_addr = 32'h30; bus.p0_we = 1'b0;
    mid();
    chk1 ("t3_c0_p1_gnt",    bus.p1_gnt,    1'b1);
    chk1 ("t3_c0_p0_gnt",    bus.p0_gnt,    1'b0);
    chk1 ("t3_c0_mem_we",    bus.mem_we,    1'b1);
    chk32("t3_c0_mem_addr",  bus.mem_addr,  32'h20);
    chk32("t3_c0_mem_wdata", bus.mem_wdata, 32'hAA);
    tick();
    bus.p0_req = 1'b1;
    mid();
    chk1("t3_c1_p1_gnt",    bus.p1_gnt,    1'b1);
    chk1("t3_c1_p0_gnt",    bus.p0_gnt,    1'b0);
    chk1("t3_c1_p1_rvalid", bus.p1_rvalid, 1'b0);
    tick();
    mid();
    chk1("t3_c2_p1_gnt", bus.p1_gnt, 1'b1);
    chk1("t3_c2_p0_gnt", bus.p0_gnt, 1'b0);
    tick();
    bus.p1_lock = 1'b0; bus.p1_req = 1'b0;
    mid();
    chk1("t3_c3_p0_gnt", bus.p0_gnt, 1'b0);
    chk1("t3_c3_mem_en", bus.mem_en, 1'b0);
    tick();
    mid();
    chk1 ("t3_c4_p0_gnt",   bus.p0_gnt,   1'b1);
    chk32("t3_c4_mem_addr", bus.mem_addr, 32'h30);
    tick();
    bus.p0_req = 1'b0; bus.p1_we = 1'b0;
    tick();

    // Alternating reads p0@4, p1@8, p0@C
    bus.p0_req = 1'b1; bus.p0_addr = 32'h4;
    mid();
    chk1("t4_c0_p0_gnt", bus.p0_gnt, 1'b1);
    tick();
    bus.p0_req = 1'b0; bus.p1_req = 1'b1; bus.p1_addr = 32'h8;
    mid();
    chk1 ("t4_c1_p1_gnt",    bus.p1_gnt,    1'b1);
    chk1 ("t4_c1_p0_rvalid", bus.p0_rvalid, 1'b1);
    chk32("t4_c1_p0_rdata",  bus.p0_rdata,  32'hA5A50004);
    chk1 ("t4_c1_p1_rvalid", bus.p1_rvalid, 1'b0);
    tick();
    bus.p1_req = 1'b0; bus.p0_req = 1'b1; bus.p0_addr = 32'hC;
    mid();
    chk1 ("t4_c2_p0_gnt",    bus.p0_gnt,    1'b1);
    chk1 ("t4_c2_p1_rvalid", bus.p1_rvalid, 1'b1);
    chk32("t4_c2_p1_rdata",  bus.p1_rdata,  32'hA5A50008);
    chk1 ("t4_c2_p0_rvalid", bus.p0_rvalid, 1'b0);
    tick();
    bus.p0_req = 1'b0;
    mid();
    chk1 ("t4_c3_p0_rvalid", bus.p0_rvalid, 1'b1);
    chk32("t4_c3_p0_rdata",  bus.p0_rdata,  32'hA5A5000C);
    chk1 ("t4_c3_p1_rvalid", bus.p1_rvalid, 1'b0);
    tick();

    // Reset in the cycle after a locked p1 read grant
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_lock = 1'b1; bus.p1_addr = 32'h40;
    mid();
    chk1("t5_c0_p1_gnt", bus.p1_gnt, 1'b1);
    tick();
    reset = 1'b1; bus.p0_req = 1'b1;
    mid();
    chk1("t5_rst_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk1("t5_rst_p0_gnt",    bus.p0_gnt,    1'b0);
    chk1("t5_rst_p1_gnt",    bus.p1_gnt,    1'b0);
    chk1("t5_rst_mem_en",    bus.mem_en,    1'b0);
    tick();
    reset = 1'b0;
    mid();
    chk1 ("t5_post_p0_gnt",    bus.p0_gnt,    1'b1);
    chk1 ("t5_post_p1_gnt",    bus.p1_gnt,    1'b0);
    chk1 ("t5_post_p1_rvalid", bus.p1_rvalid, 1'b0);
    chk32("t5_post_p1_rdata",  bus.p1_rdata,  32'h0);
    tick();

    // Idle: memory port fields stay zero regardless of request-side fields
    bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.p1_lock = 1'b0;
    bus.p0_we = 1'b1; bus.p1_we = 1'b1;
    bus.p0_addr = 32'h1234; bus.p1_addr = 32'h5678;
    bus.p0_wdata = 32'hCAFE0000; bus.p1_wdata = 32'h0000BEEF;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk1 ($sformatf("t6_mem_en_c%0d", k),    bus.mem_en,    1'b0);
      chk1 ($sformatf("t6_mem_we_c%0d", k),    bus.mem_we,    1'b0);
      chk32($sformatf("t6_mem_addr_c%0d", k),  bus.mem_addr,  32'h0);
      chk32($sformatf("t6_mem_wdata_c%0d", k), bus.mem_wdata, 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
